// File: rtl/shifter_pipe_if.sv
// Stream bundle for shifter_pipe: operand beat in, shifted result beat out.
// master drives the input beat and out_ready; slave is the shifter.
interface shifter_pipe_if #(
  parameter int N = 32,
  parameter int S = $clog2(N)
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [S-1:0] in_s;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_y;
  logic         out_zero;

  modport master (
    output in_valid, in_a, in_s, in_op, out_ready,
    input  in_ready, out_valid, out_y, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_s, in_op, out_ready,
    output in_ready, out_valid, out_y, out_zero
  );
endinterface

// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready.
// One shift stage per shift-amount bit; stage k shifts by 2^k.
// Build option: SHIFTER_STAGE_REGS_EN registers every stage (latency S);
// without it the stages are combinational into one output register (latency 1).

// One shift stage: shifts by SH positions when en is set, else passes through.
module shifter_pipe_stage #(
  parameter int N  = 32,
  parameter int SH = 1
) (
  input  logic [N-1:0] a,
  input  logic [1:0]   op,
  input  logic         sgn,
  input  logic         en,
  output logic [N-1:0] y
);
  // Fill source depends on the op; SRA uses the sign captured at input.
  always_comb begin
    y = a;
    if (en) begin
      case (op)
        2'b00:   y = {a[N-SH-1:0], {SH{1'b0}}};
        2'b01:   y = {{SH{1'b0}}, a[N-1:SH]};
        2'b10:   y = {{SH{sgn}}, a[N-1:SH]};
        default: y = {a[SH-1:0], a[N-1:SH]};
      endcase
    end
  end
endmodule

module shifter_pipe #(
  parameter int N = 32,
  parameter int S = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  shifter_pipe_if.slave  bus
);
  if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("shifter_pipe: N must be a power of two and at least 4");
  end

  // Beat carried between stages: remaining amount bits travel with the data.
  typedef struct packed {
    logic         vld;
    logic [1:0]   op;
    logic [S-1:0] amt;
    logic         sgn;
    logic [N-1:0] dat;
  } beat_t;

  logic         advance;
  logic         out_vld;
  logic [N-1:0] out_dat;
  beat_t        stg_in  [S];
  beat_t        stg_out [S-1];
  logic [N-1:0] shf     [S];

  // Single global stall: everything moves when the output slot frees up.
  assign advance      = bus.out_ready | ~out_vld;
  assign bus.in_ready = advance;

  assign stg_in[0] = '{vld: bus.in_valid & advance, op: bus.in_op, amt: bus.in_s,
                       sgn: bus.in_a[N-1], dat: bus.in_a};

  for (genvar k = 0; k < S; k++) begin : g_stage
    shifter_pipe_stage #(.N(N), .SH(1 << k)) u_stage (
      .a   (stg_in[k].dat),
      .op  (stg_in[k].op),
      .sgn (stg_in[k].sgn),
      .en  (stg_in[k].amt[k]),
      .y   (shf[k])
    );
    if (k < S - 1) begin : g_fwd
      assign stg_out[k] = '{vld: stg_in[k].vld, op: stg_in[k].op, amt: stg_in[k].amt,
                            sgn: stg_in[k].sgn, dat: shf[k]};
    end
  end

`ifdef SHIFTER_STAGE_REGS_EN
  beat_t stg_q [S-1];

  // Inter-stage registers; only the valid bits need a defined reset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < S - 1; k++) stg_q[k].vld <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < S - 1; k++) stg_q[k] <= stg_out[k];
    end
  end

  for (genvar k = 1; k < S; k++) begin : g_link
    assign stg_in[k] = stg_q[k-1];
  end
`else
  for (genvar k = 1; k < S; k++) begin : g_link
    assign stg_in[k] = stg_out[k-1];
  end
`endif

  // Output register, shared by both builds; holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (advance) begin
      out_vld <= stg_in[S-1].vld;
      out_dat <= shf[S-1];
    end
  end

  assign bus.out_valid = out_vld;
  assign bus.out_y     = out_dat;
  assign bus.out_zero  = ~|out_dat;
endmodule

// File: tb/tb_shifter_pipe.sv
// Bench for shifter_pipe: an N=8 instance for the fixed vector table and an
// N=32 instance for streams, stalls, bubbles and reset. A single negedge
// monitor owns the scoreboards and every comparison.
module tb_shifter_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shifter_pipe_if #(.N(8))  if8  ();
  shifter_pipe_if #(.N(32)) if32 ();
  shifter_pipe #(.N(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  shifter_pipe #(.N(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32));

`ifdef SHIFTER_STAGE_REGS_EN
  localparam int LAT8  = 3;
  localparam int LAT32 = 5;
`else
  localparam int LAT8  = 1;
  localparam int LAT32 = 1;
`endif

  typedef struct { logic [7:0] a; logic [2:0] s; logic [1:0] op; logic [7:0] y; logic z; } vec_t;
  typedef struct { logic [31:0] y; logic z; int cyc; bit lat; } exp_t;

  exp_t        q8[$], q32[$];
  int          n_vec = 0, n_err = 0, cyc = 0;
  logic [31:0] nx_y [2];
  logic        nx_z [2];
  bit          nx_lat [2];
  bit          hang = 0, hang_done = 0, final_req = 0, final_done = 0;
  bit          rst_chk = 0, started = 0, done6 = 0;
  bit          stall_prev [2];
  logic [31:0] py [2];
  logic        pz [2];

  logic [1:0]  ov, orr, iv, ir, oz;
  logic [31:0] oy [2];
  assign ov    = {if32.out_valid, if8.out_valid};
  assign orr   = {if32.out_ready, if8.out_ready};
  assign iv    = {if32.in_valid,  if8.in_valid};
  assign ir    = {if32.in_ready,  if8.in_ready};
  assign oz    = {if32.out_zero,  if8.out_zero};
  assign oy[0] = {24'd0, if8.out_y};
  assign oy[1] = if32.out_y;

  // Behavioural reference: plain arithmetic on a 64-bit container.
  function automatic logic [31:0] model(input logic [31:0] a, input int s,
                                        input logic [1:0] op, input int w);
    longint unsigned m, x, r;
    longint          sx;
    m = (64'd1 << w) - 64'd1;
    x = 64'(a) & m;
    case (op)
      2'd0: r = (x << s) & m;
      2'd1: r = x >> s;
      2'd2: begin
        sx = x[w-1] ? longint'(x | ~m) : longint'(x);
        r  = longint'(sx >>> s) & m;
      end
      default: r = ((x >> s) | (x << (w - s))) & m;
    endcase
    return r[31:0];
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s N=%0d: got %h, expected %h (cycle %0d)", nm, (d == 0) ? 8 : 32, act, exp, cyc);
    end
  endtask

  // Monitor: samples mid-cycle, checks handshake rules and pops the scoreboards.
  always @(negedge clk) begin
    exp_t e;
    int   qs;
    cyc++;
    if (rst_chk) begin
      for (int d = 0; d < 2; d++) begin
        chk("rst_out_valid", d, 32'(ov[d]), 32'd0);
        chk("rst_out_y",     d, oy[d],      32'd0);
        chk("rst_out_zero",  d, 32'(oz[d]), 32'd1);
        chk("rst_in_ready",  d, 32'(ir[d]), 32'd1);
      end
    end
    rst_chk = !rst_n;
    if (!rst_n) begin
      q8.delete();
      q32.delete();
      started = 1;
      stall_prev[0] = 0;
      stall_prev[1] = 0;
    end else if (started) begin
      for (int d = 0; d < 2; d++) begin
        chk("in_ready", d, 32'(ir[d]), 32'(!(ov[d] && !orr[d])));
        if (stall_prev[d]) begin
          chk("stall_out_y",     d, oy[d],      py[d]);
          chk("stall_out_zero",  d, 32'(oz[d]), 32'(pz[d]));
          chk("stall_out_valid", d, 32'(ov[d]), 32'd1);
        end
        if (ov[d] && orr[d]) begin
          qs = (d == 0) ? q8.size() : q32.size();
          if (qs == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_out N=%0d: got out_y %h, expected no beat (cycle %0d)",
                     (d == 0) ? 8 : 32, oy[d], cyc);
          end else begin
            if (d == 0) e = q8.pop_front(); else e = q32.pop_front();
            chk("out_y",    d, oy[d],      e.y);
            chk("out_zero", d, 32'(oz[d]), 32'(e.z));
            if (e.lat) chk("latency", d, 32'(cyc - e.cyc), 32'((d == 0) ? LAT8 : LAT32));
          end
        end
        if (iv[d] && ir[d]) begin
          e.y = nx_y[d]; e.z = nx_z[d]; e.cyc = cyc; e.lat = nx_lat[d];
          if (d == 0) q8.push_back(e); else q32.push_back(e);
        end
        stall_prev[d] = ov[d] && !orr[d];
        py[d] = oy[d];
        pz[d] = oz[d];
      end
    end
    if (hang && !hang_done) begin
      hang_done = 1;
      n_vec++;
      n_err++;
      $display("FAIL in_ready_timeout: got no acceptance, expected one within 200 cycles");
    end
    if (final_req && !final_done) begin
      final_done = 1;
      chk("drain_pending", 0, 32'(q8.size()),  32'd0);
      chk("drain_pending", 1, 32'(q32.size()), 32'd0);
    end
  end

  // Offer one beat and wait (bounded) until it is accepted.
  task automatic send(input int d, input logic [31:0] a, input int s, input logic [1:0] op,
                      input logic [31:0] y, input logic z, input bit lat);
    @(posedge clk); #1;
    nx_y[d] = y; nx_z[d] = z; nx_lat[d] = lat;
    if (d == 0) begin
      if8.in_valid = 1'b1; if8.in_a = a[7:0]; if8.in_s = s[2:0]; if8.in_op = op;
    end else begin
      if32.in_valid = 1'b1; if32.in_a = a; if32.in_s = s[4:0]; if32.in_op = op;
    end
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ir[d]) return;
    end
    hang = 1;
  endtask

  task automatic rnd_send(input int d, input bit lat);
    int          w  = (d == 0) ? 8 : 32;
    logic [31:0] a  = $urandom;
    int          s  = $urandom_range(0, w - 1);
    logic [1:0]  op = 2'($urandom_range(0, 3));
    logic [31:0] y  = model(a, s, op, w);
    send(d, a, s, op, y, (y == 32'd0), lat);
  endtask

  task automatic idle(input int d);
    @(posedge clk); #1;
    if (d == 0) if8.in_valid = 1'b0; else if32.in_valid = 1'b0;
  endtask

  initial begin
    vec_t tbl [15];
    tbl[0]  = '{8'h96, 3'd3, 2'd0, 8'hB0, 1'b0};
    tbl[1]  = '{8'h96, 3'd3, 2'd1, 8'h12, 1'b0};
    tbl[2]  = '{8'h96, 3'd3, 2'd2, 8'hF2, 1'b0};
    tbl[3]  = '{8'h96, 3'd3, 2'd3, 8'hD2, 1'b0};
    tbl[4]  = '{8'h80, 3'd7, 2'd2, 8'hFF, 1'b0};
    tbl[5]  = '{8'h80, 3'd7, 2'd1, 8'h01, 1'b0};
    tbl[6]  = '{8'h01, 3'd7, 2'd0, 8'h80, 1'b0};
    tbl[7]  = '{8'hA5, 3'd0, 2'd0, 8'hA5, 1'b0};
    tbl[8]  = '{8'hA5, 3'd0, 2'd1, 8'hA5, 1'b0};
    tbl[9]  = '{8'hA5, 3'd0, 2'd2, 8'hA5, 1'b0};
    tbl[10] = '{8'hA5, 3'd0, 2'd3, 8'hA5, 1'b0};
    tbl[11] = '{8'h0F, 3'd4, 2'd0, 8'hF0, 1'b0};
    tbl[12] = '{8'h10, 3'd5, 2'd1, 8'h00, 1'b1};
    tbl[13] = '{8'h01, 3'd1, 2'd3, 8'h80, 1'b0};
    tbl[14] = '{8'h7F, 3'd7, 2'd2, 8'h00, 1'b1};

    rst_n = 1'b0;
    if8.in_valid  = 1'b0; if8.in_a  = '0; if8.in_s  = '0; if8.in_op  = '0; if8.out_ready  = 1'b1;
    if32.in_valid = 1'b0; if32.in_a = '0; if32.in_s = '0; if32.in_op = '0; if32.out_ready = 1'b1;
    for (int d = 0; d < 2; d++) begin nx_y[d] = '0; nx_z[d] = 1'b1; nx_lat[d] = 0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fixed vectors on N=8, back to back, exact latency.
    for (int i = 0; i < 15; i++)
      send(0, {24'd0, tbl[i].a}, int'(tbl[i].s), tbl[i].op, {24'd0, tbl[i].y}, tbl[i].z, 1);
    idle(0);
    repeat (LAT8 + 2) @(posedge clk);

    // 20-beat stream with a 5-cycle output stall in the middle.
    fork
      for (int i = 0; i < 20; i++) rnd_send(1, 0);
      begin
        repeat (8) @(posedge clk);
        #1 if32.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 if32.out_ready = 1'b1;
      end
    join
    idle(1);
    repeat (LAT32 + 3) @(posedge clk);

    // Bubbles: valid every other cycle.
    for (int i = 0; i < 8; i++) begin
      rnd_send(1, 1);
      idle(1);
    end
    repeat (LAT32 + 3) @(posedge clk);

    // Reset with beats in flight; none may surface afterwards.
    #1 if32.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if32.in_valid = 1'b1; if32.in_a = $urandom; if32.in_s = 5'd2; if32.in_op = 2'd1;
      nx_y[1] = model(if32.in_a, 2, 2'd1, 32); nx_z[1] = (nx_y[1] == 32'd0); nx_lat[1] = 0;
    end
    @(posedge clk); #1;
    if32.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    if32.out_ready = 1'b1;
    repeat (LAT32 + 2) @(posedge clk);
    send(1, 32'h0000_0001, 31, 2'd0, 32'h8000_0000, 1'b0, 1);
    idle(1);
    repeat (LAT32 + 3) @(posedge clk);

    // 1000 random beats with random back-pressure.
    fork
      begin
        for (int i = 0; i < 1000; i++) rnd_send(1, 0);
        done6 = 1;
      end
      while (!done6) begin
        @(posedge clk); #1;
        if32.out_ready = 1'($urandom_range(0, 1));
      end
    join
    @(posedge clk); #1;
    if32.out_ready = 1'b1;
    if32.in_valid  = 1'b0;

    for (int t = 0; t < 100 && (q8.size() != 0 || q32.size() != 0); t++) @(negedge clk);
    @(posedge clk); #1 final_req = 1;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
